// File: rtl/ram_readout_ctrl.sv
// Readout sequencer for the ping-pong sample buffer's read side.
// It cuts the buffer's endless circular read stream into DEPTH-sample frames marked with sof/eof.
module ram_readout_ctrl #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 256,
    parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             enable_i,
    input  logic             buf_rdy_i,
    input  logic [WIDTH-1:0] buf_data_i,
    input  logic             buf_valid_i,
    output logic             buf_ready_o,
    output logic [WIDTH-1:0] m_data_o,
    output logic             m_valid_o,
    input  logic             m_ready_i,
    output logic             m_sof_o,
    output logic             m_eof_o,
    output logic             busy_o,
    output logic             frame_drop_o,
    output logic [15:0]      frame_count_o,
    output logic [7:0]       drop_count_o
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_BUF,
        ST_STREAM,
        ST_DRAIN
    } state_e;

    state_e           state;
    logic [CNT_W-1:0] cnt;
    logic             pending;
    logic             in_hs;
    logic             out_hs;

    // Pull only while the frame is incomplete and the output stage can take a sample.
    assign buf_ready_o = (state == ST_STREAM) && (cnt < CNT_FULL) && (!m_valid_o || m_ready_i);
    assign in_hs       = buf_valid_i && buf_ready_o;
    assign out_hs      = m_valid_o && m_ready_i;
    assign busy_o      = (state != ST_IDLE);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state         <= ST_IDLE;
            cnt           <= '0;
            pending       <= 1'b0;
            m_data_o      <= '0;
            m_valid_o     <= 1'b0;
            m_sof_o       <= 1'b0;
            m_eof_o       <= 1'b0;
            frame_drop_o  <= 1'b0;
            frame_count_o <= '0;
            drop_count_o  <= '0;
        end else begin
            frame_drop_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (enable_i) begin
                        state <= ST_WAIT_BUF;
                    end
                end

                ST_WAIT_BUF: begin
                    if (!enable_i) begin
                        state <= ST_IDLE;
                    end else if (buf_rdy_i) begin
                        state <= ST_STREAM;
                        cnt   <= '0;
                    end
                end

                ST_STREAM: begin
                    if (buf_rdy_i) begin
                        // Bank swapped under us: restart the frame, drop any sample arriving now.
                        cnt          <= '0;
                        frame_drop_o <= 1'b1;
                        if (drop_count_o != 8'hFF) begin
                            drop_count_o <= drop_count_o + 8'd1;
                        end
                        if (out_hs) begin
                            m_valid_o <= 1'b0;
                        end
                    end else if (in_hs) begin
                        m_data_o  <= buf_data_i;
                        m_valid_o <= 1'b1;
                        m_sof_o   <= (cnt == '0);
                        m_eof_o   <= (cnt == CNT_LAST);
                        cnt       <= cnt + CNT_W'(1);
                        if (cnt == CNT_LAST) begin
                            state <= ST_DRAIN;
                        end
                    end else if (out_hs) begin
                        m_valid_o <= 1'b0;
                    end
                end

                ST_DRAIN: begin
                    if (out_hs) begin
                        m_valid_o <= 1'b0;
                        if (m_eof_o) begin
                            frame_count_o <= frame_count_o + 16'd1;
                        end
                    end
                    // Leave only once the eof sample has gone; a bank seen meanwhile restarts at once.
                    if (!m_valid_o) begin
                        pending <= 1'b0;
                        if (!enable_i) begin
                            state <= ST_IDLE;
                        end else if (pending || buf_rdy_i) begin
                            state <= ST_STREAM;
                            cnt   <= '0;
                        end else begin
                            state <= ST_WAIT_BUF;
                        end
                    end else if (buf_rdy_i) begin
                        pending <= 1'b1;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_readout_ctrl.sv
// Self-checking bench for ram_readout_ctrl (DEPTH=8): random data and stalls against a frame-level model.
module tb_ram_readout_ctrl;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned DEPTH = 8;

    typedef logic [WIDTH+1:0] item_t;  // {sof, eof, data}

    logic             clk_i       = 1'b0;
    logic             rst_i       = 1'b1;
    logic             enable_i    = 1'b0;
    logic             buf_rdy_i   = 1'b0;
    logic [WIDTH-1:0] buf_data_i  = '0;
    logic             buf_valid_i = 1'b0;
    logic             buf_ready_o;
    logic [WIDTH-1:0] m_data_o;
    logic             m_valid_o;
    logic             m_ready_i   = 1'b1;
    logic             m_sof_o;
    logic             m_eof_o;
    logic             busy_o;
    logic             frame_drop_o;
    logic [15:0]      frame_count_o;
    logic [7:0]       drop_count_o;

    ram_readout_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .enable_i     (enable_i),
        .buf_rdy_i    (buf_rdy_i),
        .buf_data_i   (buf_data_i),
        .buf_valid_i  (buf_valid_i),
        .buf_ready_o  (buf_ready_o),
        .m_data_o     (m_data_o),
        .m_valid_o    (m_valid_o),
        .m_ready_i    (m_ready_i),
        .m_sof_o      (m_sof_o),
        .m_eof_o      (m_eof_o),
        .busy_o       (busy_o),
        .frame_drop_o (frame_drop_o),
        .frame_count_o(frame_count_o),
        .drop_count_o (drop_count_o)
    );

    always #5 clk_i = ~clk_i;

    int               vectors    = 0;
    int               miscompares = 0;
    int               in_cnt     = 0;
    int               gaps       = 0;
    int               rdy_mode   = 0;  // 0 high, 1 toggle, 2 random, 3 low
    int               exp_frames = 0;
    int               exp_drops  = 0;
    bit               prev_stall = 1'b0;
    item_t            prev_item  = '0;
    item_t            rx_q[$];
    item_t            exp_q[$];
    logic [WIDTH-1:0] src_q[$];

    // Model: a sample's markers follow from its position within the frame.
    function automatic void expect_sample(input logic [WIDTH-1:0] d, input int idx);
        exp_q.push_back({(idx == 0), (idx == int'(DEPTH) - 1), d});
    endfunction

    function automatic void load_frame();
        logic [WIDTH-1:0] d;
        for (int i = 0; i < int'(DEPTH); i++) begin
            d = $urandom;
            src_q.push_back(d);
            expect_sample(d, i);
        end
    endfunction

    // One clock: drive at posedge+1, observe at negedge, return at next posedge+1.
    task automatic cycle();
        if (src_q.size() > 0 && !(gaps != 0 && $urandom_range(0, 3) == 0)) begin
            buf_valid_i = 1'b1;
            buf_data_i  = src_q[0];
        end else begin
            buf_valid_i = 1'b0;
            buf_data_i  = $urandom;
        end
        case (rdy_mode)
            0:       m_ready_i = 1'b1;
            1:       m_ready_i = ~m_ready_i;
            2:       m_ready_i = 1'($urandom_range(0, 1));
            default: m_ready_i = 1'b0;
        endcase
        @(negedge clk_i);
        if (prev_stall) begin
            vectors++;
            if (!m_valid_o || {m_sof_o, m_eof_o, m_data_o} !== prev_item) begin
                miscompares++;
                $display("FAIL stall_hold: got v=%b %h expected v=1 %h", m_valid_o,
                         {m_sof_o, m_eof_o, m_data_o}, prev_item);
            end
        end
        prev_stall = m_valid_o && !m_ready_i;
        prev_item  = {m_sof_o, m_eof_o, m_data_o};
        if (m_valid_o && m_ready_i) rx_q.push_back({m_sof_o, m_eof_o, m_data_o});
        if (buf_valid_i && buf_ready_o) begin
            in_cnt++;
            void'(src_q.pop_front());
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        #1;
        vectors++;
        if ({m_data_o, m_valid_o, m_sof_o, m_eof_o, buf_ready_o, busy_o, frame_drop_o} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: got data=%h v=%b s=%b e=%b rdy=%b busy=%b drop=%b expected all 0",
                     m_data_o, m_valid_o, m_sof_o, m_eof_o, buf_ready_o, busy_o, frame_drop_o);
        end
        vectors++;
        if (frame_count_o !== 16'd0 || drop_count_o !== 8'd0) begin
            miscompares++;
            $display("FAIL reset_counts: got frames=%0d drops=%0d expected 0 0", frame_count_o, drop_count_o);
        end
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        cycle();
        vectors++;
        if (busy_o !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_after_reset: got busy=%b expected 0", busy_o);
        end
    endtask

    task automatic test_single_frame();
        int start;
        rdy_mode = 0;
        gaps     = 0;
        enable_i = 1'b1;
        cycle();
        load_frame();
        start     = in_cnt;
        buf_rdy_i = 1'b1;
        cycle();
        buf_rdy_i = 1'b0;
        vectors++;
        if (m_valid_o !== 1'b0) begin
            miscompares++;
            $display("FAIL first_latency_early: got valid=%b expected 0", m_valid_o);
        end
        cycle();
        vectors++;
        if ({m_valid_o, m_sof_o, m_data_o} !== {1'b1, 1'b1, exp_q[0][WIDTH-1:0]}) begin
            miscompares++;
            $display("FAIL first_sample: got v=%b sof=%b %h expected v=1 sof=1 %h",
                     m_valid_o, m_sof_o, m_data_o, exp_q[0][WIDTH-1:0]);
        end
        for (int k = 0; k < int'(DEPTH) - 1; k++) cycle();
        vectors++;
        if (in_cnt - start !== int'(DEPTH) || buf_ready_o !== 1'b0) begin
            miscompares++;
            $display("FAIL throughput_stop: got accepted=%0d ready=%b expected %0d 0",
                     in_cnt - start, buf_ready_o, DEPTH);
        end
        for (int k = 0; k < 20 && rx_q.size() < int'(DEPTH); k++) cycle();
        for (int k = 0; k < 3; k++) cycle();
        exp_frames++;
        vectors++;
        if (frame_count_o !== 16'(exp_frames) || busy_o !== 1'b1 || buf_ready_o !== 1'b0) begin
            miscompares++;
            $display("FAIL single_end: got frames=%0d busy=%b ready=%b expected %0d 1 0",
                     frame_count_o, busy_o, buf_ready_o, exp_frames);
        end
        vectors++;
        if (rx_q.size() !== exp_q.size()) begin
            miscompares++;
            $display("FAIL single_len: got %0d expected %0d", rx_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
            vectors++;
            if (rx_q[i] !== exp_q[i]) begin
                miscompares++;
                $display("FAIL single_sample %0d: got %h expected %h", i, rx_q[i], exp_q[i]);
            end
        end
        rx_q.delete();
        exp_q.delete();
    endtask

    task automatic test_backpressure();
        rdy_mode = 1;
        load_frame();
        buf_rdy_i = 1'b1;
        cycle();
        buf_rdy_i = 1'b0;
        for (int k = 0; k < 60 && rx_q.size() < int'(DEPTH); k++) cycle();
        for (int k = 0; k < 3; k++) cycle();
        exp_frames++;
        vectors++;
        if (frame_count_o !== 16'(exp_frames)) begin
            miscompares++;
            $display("FAIL bp_frames: got %0d expected %0d", frame_count_o, exp_frames);
        end
        vectors++;
        if (rx_q.size() !== exp_q.size()) begin
            miscompares++;
            $display("FAIL bp_len: got %0d expected %0d", rx_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
            vectors++;
            if (rx_q[i] !== exp_q[i]) begin
                miscompares++;
                $display("FAIL bp_sample %0d: got %h expected %h", i, rx_q[i], exp_q[i]);
            end
        end
        rx_q.delete();
        exp_q.delete();
    endtask

    task automatic test_back_to_back();
        rdy_mode = 2;
        gaps     = 1;
        for (int f = 0; f < 4; f++) begin
            load_frame();
            for (int k = $urandom_range(0, 3); k > 0; k--) cycle();
            buf_rdy_i = 1'b1;
            cycle();
            buf_rdy_i = 1'b0;
            for (int k = 0; k < 200 && rx_q.size() < int'(DEPTH) * (f + 1); k++) cycle();
            exp_frames++;
        end
        for (int k = 0; k < 3; k++) cycle();
        vectors++;
        if (frame_count_o !== 16'(exp_frames) || drop_count_o !== 8'(exp_drops)) begin
            miscompares++;
            $display("FAIL b2b_counts: got frames=%0d drops=%0d expected %0d %0d",
                     frame_count_o, drop_count_o, exp_frames, exp_drops);
        end
        vectors++;
        if (rx_q.size() !== exp_q.size()) begin
            miscompares++;
            $display("FAIL b2b_len: got %0d expected %0d", rx_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
            vectors++;
            if (rx_q[i] !== exp_q[i]) begin
                miscompares++;
                $display("FAIL b2b_sample %0d: got %h expected %h", i, rx_q[i], exp_q[i]);
            end
        end
        rx_q.delete();
        exp_q.delete();
        rdy_mode = 0;
        gaps     = 0;
    endtask

    task automatic test_bank_swap();
        int start;
        for (int i = 0; i < 3; i++) begin
            src_q.push_back(WIDTH'(i));
            expect_sample(WIDTH'(i), i);
        end
        src_q.push_back(WIDTH'(999));
        start     = in_cnt;
        buf_rdy_i = 1'b1;
        cycle();
        buf_rdy_i = 1'b0;
        for (int k = 0; k < 20 && in_cnt - start < 3; k++) cycle();
        for (int i = 0; i < int'(DEPTH); i++) begin
            src_q.push_back(WIDTH'(100 + i));
            expect_sample(WIDTH'(100 + i), i);
        end
        buf_rdy_i = 1'b1;
        cycle();
        buf_rdy_i = 1'b0;
        exp_drops++;
        vectors++;
        if (frame_drop_o !== 1'b1 || drop_count_o !== 8'(exp_drops)) begin
            miscompares++;
            $display("FAIL swap_drop: got pulse=%b drops=%0d expected 1 %0d", frame_drop_o, drop_count_o, exp_drops);
        end
        cycle();
        vectors++;
        if (frame_drop_o !== 1'b0) begin
            miscompares++;
            $display("FAIL swap_pulse_width: got %b expected 0", frame_drop_o);
        end
        for (int k = 0; k < 40 && rx_q.size() < 3 + int'(DEPTH); k++) cycle();
        for (int k = 0; k < 3; k++) cycle();
        exp_frames++;
        vectors++;
        if (frame_count_o !== 16'(exp_frames)) begin
            miscompares++;
            $display("FAIL swap_frames: got %0d expected %0d", frame_count_o, exp_frames);
        end
        vectors++;
        if (rx_q.size() !== exp_q.size()) begin
            miscompares++;
            $display("FAIL swap_len: got %0d expected %0d", rx_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
            vectors++;
            if (rx_q[i] !== exp_q[i]) begin
                miscompares++;
                $display("FAIL swap_sample %0d: got %h expected %h", i, rx_q[i], exp_q[i]);
            end
        end
        rx_q.delete();
        exp_q.delete();
    endtask

    task automatic test_drain_pending();
        int start;
        int pulses;
        load_frame();
        start     = in_cnt;
        buf_rdy_i = 1'b1;
        cycle();
        buf_rdy_i = 1'b0;
        for (int k = 0; k < 20 && in_cnt - start < int'(DEPTH); k++) cycle();
        rdy_mode = 3;
        load_frame();
        buf_rdy_i = 1'b1;
        cycle();
        buf_rdy_i = 1'b0;
        pulses    = 0;
        for (int k = 0; k < 3; k++) begin
            cycle();
            if (frame_drop_o) pulses++;
        end
        rdy_mode = 0;
        for (int k = 0; k < 60 && rx_q.size() < 2 * int'(DEPTH); k++) begin
            cycle();
            if (frame_drop_o) pulses++;
        end
        for (int k = 0; k < 3; k++) cycle();
        exp_frames += 2;
        vectors++;
        if (pulses !== 0 || drop_count_o !== 8'(exp_drops) || frame_count_o !== 16'(exp_frames)) begin
            miscompares++;
            $display("FAIL drain_pending: got pulses=%0d drops=%0d frames=%0d expected 0 %0d %0d",
                     pulses, drop_count_o, frame_count_o, exp_drops, exp_frames);
        end
        vectors++;
        if (rx_q.size() !== exp_q.size()) begin
            miscompares++;
            $display("FAIL drain_len: got %0d expected %0d", rx_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
            vectors++;
            if (rx_q[i] !== exp_q[i]) begin
                miscompares++;
                $display("FAIL drain_sample %0d: got %h expected %h", i, rx_q[i], exp_q[i]);
            end
        end
        rx_q.delete();
        exp_q.delete();
    endtask

    task automatic test_enable_drop();
        int start;
        rdy_mode = 2;
        load_frame();
        start     = in_cnt;
        buf_rdy_i = 1'b1;
        cycle();
        buf_rdy_i = 1'b0;
        for (int k = 0; k < 40 && in_cnt - start < 4; k++) cycle();
        enable_i = 1'b0;
        for (int k = 0; k < 60 && rx_q.size() < int'(DEPTH); k++) cycle();
        rdy_mode = 0;
        for (int k = 0; k < 3; k++) cycle();
        exp_frames++;
        vectors++;
        if (busy_o !== 1'b0 || frame_count_o !== 16'(exp_frames)) begin
            miscompares++;
            $display("FAIL enable_drop_end: got busy=%b frames=%0d expected 0 %0d", busy_o, frame_count_o, exp_frames);
        end
        vectors++;
        if (rx_q.size() !== exp_q.size()) begin
            miscompares++;
            $display("FAIL enable_drop_len: got %0d expected %0d", rx_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
            vectors++;
            if (rx_q[i] !== exp_q[i]) begin
                miscompares++;
                $display("FAIL enable_drop_sample %0d: got %h expected %h", i, rx_q[i], exp_q[i]);
            end
        end
        rx_q.delete();
        exp_q.delete();
        load_frame();
        exp_q.delete();
        buf_rdy_i = 1'b1;
        cycle();
        buf_rdy_i = 1'b0;
        for (int k = 0; k < 10; k++) cycle();
        vectors++;
        if (rx_q.size() !== 0 || m_valid_o !== 1'b0 || busy_o !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_ignores_rdy: got outputs=%0d valid=%b busy=%b expected 0 0 0",
                     rx_q.size(), m_valid_o, busy_o);
        end
        src_q.delete();
        rx_q.delete();
    endtask

    task automatic test_reset_midframe();
        int start;
        rdy_mode = 0;
        enable_i = 1'b1;
        cycle();
        load_frame();
        start     = in_cnt;
        buf_rdy_i = 1'b1;
        cycle();
        buf_rdy_i = 1'b0;
        for (int k = 0; k < 20 && in_cnt - start < 6; k++) cycle();
        rst_i = 1'b1;
        #1;
        vectors++;
        if ({m_data_o, m_valid_o, m_sof_o, m_eof_o, buf_ready_o, busy_o, frame_drop_o} !== '0
            || frame_count_o !== 16'd0 || drop_count_o !== 8'd0) begin
            miscompares++;
            $display("FAIL async_reset: got data=%h v=%b busy=%b rdy=%b frames=%0d drops=%0d expected all 0",
                     m_data_o, m_valid_o, busy_o, buf_ready_o, frame_count_o, drop_count_o);
        end
        @(posedge clk_i);
        #1;
        rst_i      = 1'b0;
        prev_stall = 1'b0;
        exp_frames = 0;
        exp_drops  = 0;
        rx_q.delete();
        exp_q.delete();
        src_q.delete();
        load_frame();
        for (int k = 0; k < 10; k++) cycle();
        vectors++;
        if (rx_q.size() !== 0 || m_valid_o !== 1'b0) begin
            miscompares++;
            $display("FAIL post_reset_quiet: got outputs=%0d valid=%b expected 0 0", rx_q.size(), m_valid_o);
        end
        buf_rdy_i = 1'b1;
        cycle();
        buf_rdy_i = 1'b0;
        for (int k = 0; k < 30 && rx_q.size() < int'(DEPTH); k++) cycle();
        for (int k = 0; k < 3; k++) cycle();
        exp_frames++;
        vectors++;
        if (frame_count_o !== 16'(exp_frames) || drop_count_o !== 8'd0) begin
            miscompares++;
            $display("FAIL post_reset_counts: got frames=%0d drops=%0d expected %0d 0",
                     frame_count_o, drop_count_o, exp_frames);
        end
        vectors++;
        if (rx_q.size() !== exp_q.size()) begin
            miscompares++;
            $display("FAIL post_reset_len: got %0d expected %0d", rx_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
            vectors++;
            if (rx_q[i] !== exp_q[i]) begin
                miscompares++;
                $display("FAIL post_reset_sample %0d: got %h expected %h", i, rx_q[i], exp_q[i]);
            end
        end
        rx_q.delete();
        exp_q.delete();
    endtask

    task automatic test_drop_saturate();
        src_q.delete();
        buf_rdy_i = 1'b1;
        cycle();
        buf_rdy_i = 1'b0;
        cycle();
        for (int n = 1; n <= 260; n++) begin
            buf_rdy_i = 1'b1;
            cycle();
            buf_rdy_i = 1'b0;
            cycle();
            exp_drops = (exp_drops < 255) ? exp_drops + 1 : 255;
            if (n == 254 || n == 260) begin
                vectors++;
                if (drop_count_o !== 8'(exp_drops)) begin
                    miscompares++;
                    $display("FAIL drop_saturate after %0d: got %0d expected %0d", n, drop_count_o, exp_drops);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_backpressure();
        test_back_to_back();
        test_bank_swap();
        test_drain_pending();
        test_enable_drop();
        test_reset_midframe();
        test_drop_saturate();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
